// File: rtl/rca_timing_pkg.sv
// Shared definitions for the ripple-carry-adder timing harness: checker FSM
// states and the active-low seven-segment codes for hex digits 0-F.
package rca_timing_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Full display byte {dp,g,f,e,d,c,b,a}, active-low, decimal point off.
   localparam logic [7:0] SEG_LUT [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   // Digit "0" with the decimal point off; the display value after reset.
   localparam logic [7:0] SEG_ZERO = 8'hC0;

   // Segment bits only (g..a) for one hex digit.
   function automatic logic [6:0] seg7(input logic [3:0] nibble);
      return SEG_LUT[nibble][6:0];
   endfunction

endpackage

// File: rtl/rca_result_checker_hex7seg.sv
// Combinational hex-digit decoder: one nibble in, seven active-low segments out.
module hex7seg
   import rca_timing_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup into the shared segment encodings.
   always_comb begin
      seg = seg7(nibble);
   end

endmodule

// File: rtl/rca_result_checker.sv
// Response-side checker for the ripple-carry-adder timing harness. Each
// launched operand set produces a golden sum that travels down a LAT-deep
// pipeline; the tail is compared with the adder's captured result. Sample
// and error counts plus the first failing operand are shown on HEX0..HEX5.
module rca_result_checker
   import rca_timing_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int LAT         = 1,
   parameter int NUM_SAMPLES = 64
) (
   input  logic             MAX10_CLK1_50,
   input  logic [1:0]       KEY,
   input  logic             launch_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [WIDTH-1:0] cap_sum,
   input  logic             cap_cout,
   output logic [15:0]      err_cnt,
   output logic [15:0]      sample_cnt,
   output logic             done,
   output logic [7:0]       HEX0,
   output logic [7:0]       HEX1,
   output logic [7:0]       HEX2,
   output logic [7:0]       HEX3,
   output logic [7:0]       HEX4,
   output logic [7:0]       HEX5
);

   localparam logic [15:0] NUM_W = 16'(NUM_SAMPLES);

   logic clk;
   logic rst_n;
   logic show_err;

   assign clk      = MAX10_CLK1_50;
   assign rst_n    = KEY[0];
   assign show_err = KEY[1];

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      return (val == 16'hFFFF) ? val : val + 16'd1;
   endfunction

   // Low byte of an operand, zero-extended when the operand is narrower.
   function automatic logic [7:0] low_byte(input logic [WIDTH-1:0] val);
      return 8'(val);
   endfunction

   state_t state;
   state_t state_nxt;

   logic [WIDTH:0]   exp_p0;
   logic [LAT-1:0]   vld_p;
   logic [WIDTH:0]   exp_p [LAT];
   logic [WIDTH-1:0] a_p   [LAT];

   logic             vld_tail;
   logic [WIDTH:0]   exp_tail;
   logic [WIDTH-1:0] a_tail;
   logic             cmp;
   logic             mismatch;
   logic [15:0]      sample_nxt;

   logic [7:0]       first_fail_a;
   logic [15:0]      disp_word;
   logic [6:0]       seg0, seg1, seg2, seg3, seg4, seg5;

   // ---- stage p0: golden sum at launch, carried one bit wider so cout survives
   assign exp_p0 = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

   // Valid bits: flushed by reset, launches ignored once the run is finished.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= launch_valid && (state != DONE);
         for (int i = 1; i < LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   // Golden sum and operand A ride alongside the valid bits; no reset needed.
   always_ff @(posedge clk) begin
      exp_p[0] <= exp_p0;
      a_p[0]   <= a;
      for (int i = 1; i < LAT; i++) begin
         exp_p[i] <= exp_p[i-1];
         a_p[i]   <= a_p[i-1];
      end
   end

   // ---- compare stage: pipeline tail lines up with the captured result
   assign vld_tail   = vld_p[LAT-1];
   assign exp_tail   = exp_p[LAT-1];
   assign a_tail     = a_p[LAT-1];
   assign cmp        = vld_tail && (state != DONE);
   assign mismatch   = cmp && ({cap_cout, cap_sum} != exp_tail);
   assign sample_nxt = sample_cnt + 16'd1;

   // Checker state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: run starts at the first compare, ends on the last sample.
   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (cmp) begin
               state_nxt = (sample_nxt == NUM_W) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cmp && (sample_nxt == NUM_W)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counters and first-failure latch; err_cnt is zero only before any failure.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sample_cnt   <= '0;
         err_cnt      <= '0;
         first_fail_a <= '0;
      end else if (cmp) begin
         sample_cnt <= sample_nxt;
         if (mismatch) begin
            err_cnt <= sat_inc16(err_cnt);
            if (err_cnt == 16'd0) begin
               first_fail_a <= low_byte(a_tail);
            end
         end
      end
   end

   // ---- display stage: registered one edge after the counters
   assign disp_word = show_err ? err_cnt : sample_cnt;

   hex7seg u_hex0 (.nibble(disp_word[3:0]),    .seg(seg0));
   hex7seg u_hex1 (.nibble(disp_word[7:4]),    .seg(seg1));
   hex7seg u_hex2 (.nibble(disp_word[11:8]),   .seg(seg2));
   hex7seg u_hex3 (.nibble(disp_word[15:12]),  .seg(seg3));
   hex7seg u_hex4 (.nibble(first_fail_a[3:0]), .seg(seg4));
   hex7seg u_hex5 (.nibble(first_fail_a[7:4]), .seg(seg5));

   // Display registers; only HEX0's decimal point carries status (lit when done).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         HEX0 <= SEG_ZERO;
         HEX1 <= SEG_ZERO;
         HEX2 <= SEG_ZERO;
         HEX3 <= SEG_ZERO;
         HEX4 <= SEG_ZERO;
         HEX5 <= SEG_ZERO;
      end else begin
         HEX0 <= {~done, seg0};
         HEX1 <= {1'b1, seg1};
         HEX2 <= {1'b1, seg2};
         HEX3 <= {1'b1, seg3};
         HEX4 <= {1'b1, seg4};
         HEX5 <= {1'b1, seg5};
      end
   end

endmodule
